booth_top: RTL and testbench
============================

BOOTH_TOP -- requirements
Module: booth_top

Interface
REQ-001 Parameter A_W, default 8: multiplicand width, signed two's complement.
REQ-002 Parameter B_W, default 8: multiplier width, signed two's complement.
REQ-003 Parameter C_W, default 15: product output width (A_W+B_W-1).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 a  input  A_W  multiplicand, interpreted as signed.
REQ-007 b  input  B_W  multiplier, signed.
REQ-008 c  output  C_W  signed product a*b, registered.

Function
REQ-009 The block SHALL compute the signed product of a and b using radix-4 (modified) Booth recoding of b: ceil(B_W/2) partial products, digits in {-2,-1,0,+1,+2}.
REQ-010 Both operands SHALL be treated as two's-complement signed, including a.
REQ-011 Stage 1 SHALL register a and b on every rising edge (no enable; new operands accepted every cycle).
REQ-012 Stage 2 SHALL Booth-encode the registered b, form sign-extended partial products of the registered a, sum them, and register the result into c.
REQ-013 Latency: operands present at rising edge k SHALL appear on c after rising edge k+1; throughput one product per cycle.
REQ-014 The internal full product SHALL be A_W+B_W bits; c SHALL be its low C_W bits (two's-complement wrap).
REQ-015 Boundary: a=-128, b=-128 (product +16384) SHALL wrap to c = -16384 (15'h4000); every other 8x8 operand pair SHALL be represented exactly.
REQ-016 Digit -2 of the most-negative a SHALL use the full-width sign-extended form with no intermediate overflow.
REQ-017 c SHALL change only on a rising clk edge or on reset assertion; no combinational path from a/b to c.

Reset
REQ-018 While rst=1, operand registers and c SHALL be 0, asynchronously on assertion.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight products; after deassertion the first valid c is the product of operands sampled at the first rising edge with rst=0, one edge later.
REQ-020 During the first post-reset edge, c SHALL hold 0 (0*0).

Structure
REQ-021 A shared package booth_pkg SHALL hold A_W/B_W/C_W defaults and the Booth digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2).
REQ-022 One sub-module booth_pp_gen SHALL take a 3-bit window of b and the multiplicand and return one sign-extended partial product; booth_top instantiates it ceil(B_W/2) times.
REQ-023 Summation SHALL be a plain adder tree within stage 2; no further pipeline registers.

Verification
REQ-024 Reset: rst=1 with a=5, b=7 -> c=0; release, hold -> c=35 two edges after release.
REQ-025 a=-128, b=127 -> c=-16256; next cycle a=-127, b=126 -> c=-16002 one cycle later (back-to-back, no bubble).
REQ-026 Corners: 127*127 -> 16129; -128*-128 -> -16384 (wrap); 0*-128 -> 0; -1*-1 -> 1.
REQ-027 Sweep: starting a=-128, b=127, each cycle i=1..255 a+=i, b-=i (8-bit wrap) -> every c equals low 15 bits of signed a*b from two edges earlier.
REQ-028 Reset asserted between two in-flight products -> c=0 immediately, neither product ever appears on c.
REQ-029 Exhaustive 65536-pair random-order check against a reference model, including the wrap case.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared constants for the radix-4 Booth multiplier: default operand and
//   product widths, the Booth digit encoding, and a helper that maps a
//   3-bit multiplier window onto its digit.
//   No ports.
package booth_pkg;

  localparam int A_W_DEF = 8;
  localparam int B_W_DEF = 8;
  localparam int C_W_DEF = 15;

  // Digit encoding: bit 2 is the sign, bits 1:0 the magnitude.
  localparam logic [2:0] ZERO = 3'b000;
  localparam logic [2:0] POS1 = 3'b001;
  localparam logic [2:0] POS2 = 3'b010;
  localparam logic [2:0] NEG1 = 3'b101;
  localparam logic [2:0] NEG2 = 3'b110;

  // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w[2] + w[1] + w[0].
  function automatic logic [2:0] booth_encode(input logic [2:0] win);
    logic [2:0] digit;
    case (win)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen
//   Forms one sign-extended Booth partial product (unshifted) from a 3-bit
//   window of the multiplier and the signed multiplicand.
//   Ports:
//     win   in  3     multiplier window {b[2i+1], b[2i], b[2i-1]}
//     mcand in  A_W   signed multiplicand
//     pp    out P_W   digit * mcand, two's complement, P_W bits
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int P_W = A_W_DEF + B_W_DEF
) (
  input  logic [2:0]     win,
  input  logic [A_W-1:0] mcand,
  output logic [P_W-1:0] pp
);

  logic [2:0]     digit;
  logic [P_W-1:0] ext;
  logic [P_W-1:0] ext2;

  assign digit = booth_encode(win);

  // Extend to the full product width before doubling/negating so that
  // -2 * (most negative mcand) cannot overflow.
  assign ext  = {{(P_W-A_W){mcand[A_W-1]}}, mcand};
  assign ext2 = ext << 1;

  always_comb begin
    case (digit)
      POS1:    pp = ext;
      POS2:    pp = ext2;
      NEG1:    pp = -ext;
      NEG2:    pp = -ext2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_top.sv
// booth_top
//   Two-stage pipelined signed multiplier using radix-4 Booth recoding.
//   Stage 1 registers the operands; stage 2 recodes b, builds the partial
//   products, sums them and registers the low C_W bits into c.
//   Ports:
//     clk  in  1    clock, rising edge
//     rst  in  1    asynchronous active-high reset
//     a    in  A_W  signed multiplicand
//     b    in  B_W  signed multiplier
//     c    out C_W  registered signed product (low C_W bits of a*b)
module booth_top
  import booth_pkg::*;
#(
  parameter int A_W = A_W_DEF,
  parameter int B_W = B_W_DEF,
  parameter int C_W = C_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [C_W-1:0] c
);

  localparam int NPP = (B_W + 1) / 2;
  localparam int P_W = A_W + B_W;

  logic [A_W-1:0] a_reg;
  logic [B_W-1:0] b_reg;
  logic [2*NPP:0] b_ext;
  logic [P_W-1:0] pp [NPP];
  logic [P_W-1:0] product;

  // Stage 1: operand capture, no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // Implicit b[-1] = 0 below the LSB; odd widths get one extra sign bit so
  // the top window is complete.
  generate
    if (2*NPP > B_W) begin : g_odd
      assign b_ext = {b_reg[B_W-1], b_reg, 1'b0};
    end else begin : g_even
      assign b_ext = {b_reg, 1'b0};
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < NPP; gi++) begin : g_pp
      booth_pp_gen #(
        .A_W(A_W),
        .P_W(P_W)
      ) u_pp (
        .win  (b_ext[2*gi+2 -: 3]),
        .mcand(a_reg),
        .pp   (pp[gi])
      );
    end
  endgenerate

  // Partial products weighted by 4^i; modulo-2^P_W addition gives the exact
  // signed product since it always fits in P_W bits.
  always_comb begin
    product = '0;
    for (int i = 0; i < NPP; i++) begin
      product = product + (pp[i] << (2*i));
    end
  end

  // Bits above C_W are deliberately dropped (two's-complement wrap).
  generate
    if (P_W > C_W) begin : g_drop
      logic unused_hi;
      assign unused_hi = ^product[P_W-1:C_W];
    end
  endgenerate

  // Stage 2: result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
    end else begin
      c <= product[C_W-1:0];
    end
  end

endmodule

// File: tb/tb_booth_top.sv
// tb_booth_top
//   Randomised/directed stimulus with a scoreboard queue; a monitor process
//   compares c against an arithmetic reference model two edges after issue.
module tb_booth_top;

  localparam int A_W = 8;
  localparam int B_W = 8;
  localparam int C_W = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [A_W-1:0] a;
  logic [B_W-1:0] b;
  logic [C_W-1:0] c;

  always #5 clk = ~clk;

  booth_top #(
    .A_W(A_W),
    .B_W(B_W),
    .C_W(C_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .a  (a),
    .b  (b),
    .c  (c)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [14:0] exp;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic in_valid;
  logic v1, v2;
  int   perm [65536];

  // Reference: plain signed integer multiply, keep low 15 bits.
  function automatic logic [14:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[14:0];
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: c=%0d (15'h%h) expected %0d (15'h%h)",
                  name, $signed(act), act, $signed(exp), exp);
  endtask

  // Drive one operand pair just after an edge and record its expected result.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    txn_t t;
    a = x;
    b = y;
    in_valid = 1'b1;
    t.a = x;
    t.b = y;
    t.exp = ref_prod(x, y);
    sb.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Tracks which cycles carry a result, independent of the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= in_valid;
      v2 <= v1;
    end
  end

  always @(negedge clk) begin
    txn_t t;
    if (v2 && !rst) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_underflow: c=%0d with no expected entry", $signed(c));
      end else begin
        t = sb.pop_front();
        $display("txn a=%0d b=%0d c=%0d exp=%0d", $signed(t.a), $signed(t.b), $signed(c), $signed(t.exp));
        check("product", c, t.exp);
      end
    end
  end

  initial begin
    int j, tmp;
    logic [7:0] sa, sbv;

    rst = 1'b1;
    in_valid = 1'b0;
    a = 8'd5;
    b = 8'd7;
    #2;
    check("reset_c", c, 15'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_c", c, 15'd0);

    // Release with 5*7 held: 35 appears two edges later, 0 after the first.
    rst = 1'b0;
    issue(8'd5, 8'd7);
    check("first_post_reset_edge", c, 15'd0);
    issue(8'd5, 8'd7);

    // Back-to-back extremes.
    issue(8'h80, 8'd127);
    issue(8'h81, 8'd126);

    // Corners.
    issue(8'd127, 8'd127);
    issue(8'h80, 8'h80);
    issue(8'd0, 8'h80);
    issue(8'hFF, 8'hFF);
    idle(3);

    // Sweep with growing steps.
    sa = 8'h80;
    sbv = 8'd127;
    issue(sa, sbv);
    for (int i = 1; i <= 255; i++) begin
      sa = sa + 8'(i);
      sbv = sbv - 8'(i);
      issue(sa, sbv);
    end

    // Reset between in-flight products: nonzero c is present, two more are
    // in the pipe; reset must zero c at once and lose both.
    issue(8'd100, 8'd3);
    issue(8'd90, 8'd2);
    check("pre_reset_c", c, ref_prod(8'd100, 8'd3));
    a = 8'd77;
    b = 8'd55;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_reset_c", c, 15'd0);
    sb.delete();
    @(posedge clk);
    #1;
    check("mid_reset_hold_c", c, 15'd0);
    a = 8'd0;
    b = 8'd0;
    rst = 1'b0;
    issue(8'd0, 8'd0);
    issue(8'd0, 8'd0);
    issue(8'd0, 8'd0);

    // Every operand pair in random order.
    for (int i = 0; i < 65536; i++) perm[i] = i;
    for (int i = 65535; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 65536; i++) begin
      issue(8'(perm[i] >> 8), 8'(perm[i]));
    end
    idle(4);

    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
